dmem_ws: RTL and testbench

DMEM_WS -- requirements
Module: dmem_ws

---
 rtl/dmem_ws.sv | 84 ++++++++
 tb/tb_dmem_ws.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ws.sv
// Wait-state data memory for the pipeline memory stage: accepts one access in
// IDLE, completes it WAIT+1 cycles later with a one-cycle ready pulse.
module dmem_ws #(
  parameter int ADDR_W = 6,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        stall,
  output logic        err
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t             state, state_nx;
  logic [3:0]         cnt;
  logic [ADDR_W+1:0]  cap_addr;
  logic               cap_we;
  logic [31:0]        cap_wdata;
  logic [31:0]        mem [2**ADDR_W];
  logic [ADDR_W-1:0]  idx;
  logic               misaligned;
  logic               unused_addr;

  assign idx         = cap_addr[ADDR_W+1:2];
  assign misaligned  = |cap_addr[1:0];
  assign unused_addr = &{1'b0, addr[31:ADDR_W+2]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (req) state_nx = (WAIT > 0) ? ST_WAIT : ST_DONE;
      ST_WAIT: if (cnt == 4'd1) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Request fields are latched at acceptance so the datapath may move on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      cap_addr  <= '0;
      cap_we    <= 1'b0;
      cap_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req) begin
          cnt       <= 4'(WAIT);
          cap_addr  <= addr[ADDR_W+1:0];
          cap_we    <= we;
          cap_wdata <= wdata;
        end
        ST_WAIT: cnt <= cnt - 4'd1;
        default: ;
      endcase
    end
  end

  // State is reset asynchronously, so an abort in DONE never reaches this write.
  always_ff @(posedge clk) begin
    if (state == ST_DONE && cap_we && !misaligned) mem[idx] <= cap_wdata;
  end

  always_comb begin
    ready = (state == ST_DONE);
    err   = ready & misaligned;
    rdata = '0;
    if (ready && !cap_we && !misaligned) rdata = mem[idx];
    stall = req & ~ready;
  end

endmodule

// File: tb/tb_dmem_ws.sv
// Directed bench for dmem_ws: two instances (WAIT=2 and WAIT=0) checked every
// cycle against a timestamp-based transaction model, plus literal expectations.
module tb_dmem_ws;

  localparam int AW = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_v, we_v;
  logic [63:0] addr_all, wdata_all;
  logic [63:0] rd_all;
  logic [1:0]  rdy, stl, er;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_ws #(.ADDR_W(AW), .WAIT(2)) dut_a (
    .clk(clk), .reset(reset), .req(req_v[0]), .we(we_v[0]),
    .addr(addr_all[31:0]), .wdata(wdata_all[31:0]),
    .rdata(rd_all[31:0]), .ready(rdy[0]), .stall(stl[0]), .err(er[0]));

  dmem_ws #(.ADDR_W(AW), .WAIT(0)) dut_b (
    .clk(clk), .reset(reset), .req(req_v[1]), .we(we_v[1]),
    .addr(addr_all[63:32]), .wdata(wdata_all[63:32]),
    .rdata(rd_all[63:32]), .ready(rdy[1]), .stall(stl[1]), .err(er[1]));

  function automatic int wt(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[dut%0d] @%0t: got %h, expected %h", nm, d, $time, act, exp);
    end
  endtask

  // Model: an accepted transaction completes in cycle accept_edge+WAIT.
  int          cyc = 0;
  bit          pend [2];
  int          tdone [2];
  logic [31:0] ca [2];
  logic [31:0] cw [2];
  bit          cwe [2];
  logic [31:0] mm [2][64];
  bit          kn [2][64];

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!reset) pend[d] = 1'b0;
      else if (pend[d] && cyc == tdone[d] + 1) begin
        if (cwe[d] && ca[d][1:0] == 2'b00) begin
          mm[d][ca[d][AW+1:2]] = cw[d];
          kn[d][ca[d][AW+1:2]] = 1'b1;
        end
        pend[d] = 1'b0;
      end else if (!pend[d] && req_v[d]) begin
        pend[d]  = 1'b1;
        tdone[d] = cyc + wt(d);
        ca[d]    = addr_all[d*32 +: 32];
        cw[d]    = wdata_all[d*32 +: 32];
        cwe[d]   = we_v[d];
      end
    end
  end

  bit   rdy_e, mis;
  int   ix;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      rdy_e = reset && pend[d] && cyc == tdone[d];
      mis   = ca[d][1:0] != 2'b00;
      ix    = int'(ca[d][AW+1:2]);
      chk("ready", d, 32'(rdy[d]), 32'(rdy_e));
      chk("err",   d, 32'(er[d]),  32'(rdy_e && mis));
      chk("stall", d, 32'(stl[d]), 32'(req_v[d] && !rdy_e));
      if (rdy_e && !cwe[d] && !mis) begin
        if (kn[d][ix]) chk("rdata", d, rd_all[d*32 +: 32], mm[d][ix]);
      end else begin
        chk("rdata", d, rd_all[d*32 +: 32], 32'h0);
      end
    end
  end

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int d, output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (rdy[d]) break;
      lat++;
      if (lat > 40) begin
        n_cmp++; n_bad++;
        $display("FAIL ready_timeout[dut%0d] @%0t: got no ready, expected ready within 40 cycles", d, $time);
        break;
      end
    end
  endtask

  // Called just after a rising edge; leaves req asserted after the ready edge.
  task automatic access(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdo, output bit eo, output int lat);
    req_v[d] = 1'b1;
    we_v[d]  = w;
    addr_all[d*32 +: 32]  = a;
    wdata_all[d*32 +: 32] = wd;
    wait_ready(d, lat);
    rdo = rd_all[d*32 +: 32];
    eo  = er[d];
    go(1);
  endtask

  logic [31:0] r;
  bit          e;
  int          lat;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before 400us");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; req_v = '0; we_v = '0; addr_all = '0; wdata_all = '0;
    go(3);
    chk("rst_ready", 0, 32'(rdy[0]), 32'h0);
    chk("rst_err",   0, 32'(er[0]),  32'h0);
    chk("rst_rdata", 0, rd_all[31:0], 32'h0);
    chk("rst_stall", 1, 32'(stl[1]), 32'h0);
    reset = 1'b1;
    go(1);

    access(0, 1'b1, 32'h10, 32'hDEADBEEF, r, e, lat);
    chk("st_latency", 0, 32'(lat), 32'd3);
    chk("st_err", 0, 32'(e), 32'd0);
    req_v[0] = 1'b0; go(2);
    access(0, 1'b0, 32'h10, 32'h0, r, e, lat);
    chk("ld_data", 0, r, 32'hDEADBEEF);
    chk("ld_latency", 0, 32'(lat), 32'd3);

    access(0, 1'b1, 32'h13, 32'h55555555, r, e, lat);
    chk("mis_st_err", 0, 32'(e), 32'd1);
    access(0, 1'b0, 32'h10, 32'h0, r, e, lat);
    chk("mis_unchanged", 0, r, 32'hDEADBEEF);
    chk("ld_err", 0, 32'(e), 32'd0);
    access(0, 1'b0, 32'h12, 32'h0, r, e, lat);
    chk("mis_ld_rdata", 0, r, 32'h0);
    chk("mis_ld_err", 0, 32'(e), 32'd1);

    access(0, 1'b1, 32'h100, 32'h12345678, r, e, lat);
    access(0, 1'b0, 32'h0, 32'h0, r, e, lat);
    chk("wrap", 0, r, 32'h12345678);

    access(0, 1'b1, 32'h8, 32'h0BADF00D, r, e, lat);
    req_v[0] = 1'b0; go(1);
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_all[31:0] = 32'h8;
    go(1);
    req_v[0] = 1'b0; we_v[0] = 1'b1; addr_all[31:0] = 32'h40; wdata_all[31:0] = 32'hFFFFFFFF;
    wait_ready(0, lat);
    chk("commit_rdata", 0, rd_all[31:0], 32'h0BADF00D);
    chk("commit_latency", 0, 32'(lat), 32'd2);
    go(1);
    access(0, 1'b0, 32'h8, 32'h0, r, e, lat);
    chk("commit_no_write", 0, r, 32'h0BADF00D);
    req_v[0] = 1'b0; go(1);

    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_all[31:0] = 32'h20; wdata_all[31:0] = 32'hAAAAAAAA;
    go(1);
    reset = 1'b0; req_v[0] = 1'b0;
    #1;
    chk("abort_ready", 0, 32'(rdy[0]), 32'h0);
    chk("abort_err",   0, 32'(er[0]),  32'h0);
    chk("abort_rdata", 0, rd_all[31:0], 32'h0);
    go(2);
    reset = 1'b1; go(1);
    access(0, 1'b0, 32'h20, 32'h0, r, e, lat);
    n_cmp++;
    if (r === 32'hAAAAAAAA) begin
      n_bad++;
      $display("FAIL abort_no_write[dut0]: got %h, expected anything but aaaaaaaa", r);
    end
    chk("fresh_latency", 0, 32'(lat), 32'd3);

    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_all[31:0] = 32'h10; wdata_all[31:0] = 32'h77777777;
    wait_ready(0, lat);
    #2 reset = 1'b0;
    #1;
    chk("async_ready", 0, 32'(rdy[0]), 32'h0);
    chk("async_err",   0, 32'(er[0]),  32'h0);
    chk("async_rdata", 0, rd_all[31:0], 32'h0);
    req_v[0] = 1'b0;
    go(2);
    reset = 1'b1; go(1);
    access(0, 1'b0, 32'h10, 32'h0, r, e, lat);
    chk("done_abort", 0, r, 32'hDEADBEEF);
    req_v[0] = 1'b0; go(1);

    access(1, 1'b0, 32'h4, 32'h0, r, e, lat);
    chk("w0_ld_latency", 1, 32'(lat), 32'd1);
    access(1, 1'b1, 32'h4, 32'hCAFEF00D, r, e, lat);
    chk("w0_b2b_latency", 1, 32'(lat), 32'd1);
    access(1, 1'b0, 32'h4, 32'h0, r, e, lat);
    chk("w0_ld_data", 1, r, 32'hCAFEF00D);
    chk("w0_b2b_latency2", 1, 32'(lat), 32'd1);
    req_v[1] = 1'b0;
    go(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
